seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse datapath of the team's registered 4-bit adder: it computes A/B by repeated trial subtraction, one quotient bit per clock.
- Sits beside the adder in the pre-lab arithmetic unit.
- Exposes a Start/Busy/Done handshake so a controller can launch an operation and wait for the result.
- Results are held stable until the next accepted operation completes.

Parameters:
- WIDTH, 4, operand, quotient and remainder width in bits (legal range 2..16).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled on a rising edge when not Busy.
- A  input  WIDTH  dividend, unsigned; sampled with Start.
- B  input  WIDTH  divisor, unsigned; sampled with Start.
- Busy  output  1  high while an accepted operation is in progress.
- Done  output  1  one-cycle pulse; Quotient/Remainder/DivByZero are valid from this cycle.
- Quotient  output  WIDTH  A / B.
- Remainder  output  WIDTH  A mod B.
- DivByZero  output  1  high with Done when the latched B was 0.

Behaviour:
- Clock and reset:
  - One clock (Clk). Reset is synchronous and active-high; it is sampled only on the rising edge of Clk.
  - Reset has priority over all other inputs.
  - On Reset: state=IDLE; Busy=0, Done=0, Quotient=0, Remainder=0, DivByZero=0; working registers cleared.
- States: IDLE, RUN, FIN.
- IDLE or FIN, Start=1 at edge k:
  - Latch A into a dividend shift register and B into a divisor register; clear the partial remainder (WIDTH+1 bits); iteration counter = WIDTH-1.
  - If B!=0: go to RUN; Busy=1 from the cycle after edge k.
  - If B==0: go to FIN directly. At edge k the result registers load Quotient={WIDTH{1}} and Remainder=A; DivByZero=1, Done=1, Busy=0.
- IDLE or FIN, Start=0: go to or stay in IDLE. Done=0 outside FIN.
- RUN, one iteration per edge (edges k+1..k+WIDTH):
  - Partial remainder P = {P[WIDTH-1:0], dividend MSB}; dividend shifts left by one.
  - Trial difference D = P - {0,divisor}, computed in WIDTH+1 bits.
  - If D has no borrow (D MSB==0): P=D and the quotient bit = 1. Otherwise P is unchanged and the quotient bit = 0.
  - Quotient bits shift in from the LSB, MSB first.
  - The counter decrements each iteration. The iteration at counter==0 (edge k+WIDTH) writes the final quotient/remainder into the output registers, clears DivByZero, and moves to FIN.
- FIN lasts exactly one cycle: Done=1, Busy=0.
- Latency:
  - Normal case: Start at edge k gives Done high in the cycle after edge k+WIDTH (WIDTH+1 edges; 5 for WIDTH=4).
  - Divide-by-zero: Done high in the cycle after edge k.
- Output hold:
  - Quotient, Remainder and DivByZero change only at completion (or Reset).
  - During RUN they show the previous result.
- Start while Busy (RUN): ignored; the in-flight operation is unaffected and no request is queued.
- Start during FIN: accepted (back-to-back). Done is high for that one cycle and then goes low as RUN begins.
- Changes to A or B after acceptance have no effect.
- Reset mid-RUN: aborts the operation; Done never pulses for it; all outputs go to 0.
- Arithmetic:
  - Unsigned only. The quotient always fits in WIDTH bits.
  - The invariant A == Quotient*B + Remainder, with Remainder < B, holds for all B!=0.

Test Plan:
- Reset, then A=13, B=4, Start for one cycle -> Busy high for 4 cycles; Done pulses on the 5th cycle with Quotient=3, Remainder=1, DivByZero=0.
- A=15, B=1 -> Quotient=15, Remainder=0. Then A=3, B=7 -> Quotient=0, Remainder=3. Outputs hold the 15/0 values until the second Done.
- A=9, B=0 -> Done in the cycle after Start with DivByZero=1, Quotient=15, Remainder=9; Busy never asserts.
- Start A=12, B=5; pulse Start again with A=1, B=1 on the 2nd Busy cycle -> second Start ignored; result is Quotient=2, Remainder=2.
- Start A=14, B=3; assert Reset on the 2nd Busy cycle -> next cycle all outputs 0 and no Done. A fresh Start A=14, B=3 then yields Quotient=4, Remainder=2.
- Exhaustive sweep of all 256 A/B pairs with back-to-back Start held high during FIN -> every Done satisfies the quotient/remainder invariant, and Done appears every 5 cycles.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, with a
// Start/Busy/Done handshake and result registers that hold until the next completion.
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivByZero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] dividend_r, dividend_s;
    logic [WIDTH-1:0] divisor_r, divisor_s;
    logic [WIDTH:0]   prem_r, prem_s;
    logic [WIDTH-1:0] quot_r, quot_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] q_out_s, r_out_s;
    logic             dbz_s, busy_s, done_s;
    logic [WIDTH:0]   shifted_s, diff_s;

    // Trial subtraction in WIDTH+1 bits; the MSB of the result is the borrow.
    function automatic logic [WIDTH:0] trial_sub(input logic [WIDTH:0] p,
                                                 input logic [WIDTH-1:0] d);
        trial_sub = p - {1'b0, d};
    endfunction

    // Next-state, datapath and next-output logic.
    always_comb begin
        state_s    = state_r;
        dividend_s = dividend_r;
        divisor_s  = divisor_r;
        prem_s     = prem_r;
        quot_s     = quot_r;
        cnt_s      = cnt_r;
        q_out_s    = Quotient;
        r_out_s    = Remainder;
        dbz_s      = DivByZero;
        shifted_s  = {prem_r[WIDTH-1:0], dividend_r[WIDTH-1]};
        diff_s     = trial_sub(shifted_s, divisor_r);

        case (state_r)
            IDLE, FIN: begin
                if (Start) begin
                    dividend_s = A;
                    divisor_s  = B;
                    prem_s     = '0;
                    quot_s     = '0;
                    cnt_s      = CW'(WIDTH - 1);
                    if (B != '0) begin
                        state_s = RUN;
                    end else begin
                        state_s = FIN;
                        q_out_s = '1;
                        r_out_s = A;
                        dbz_s   = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                dividend_s = {dividend_r[WIDTH-2:0], 1'b0};
                if (diff_s[WIDTH] == 1'b0) begin
                    prem_s = diff_s;
                    quot_s = {quot_r[WIDTH-2:0], 1'b1};
                end else begin
                    prem_s = shifted_s;
                    quot_s = {quot_r[WIDTH-2:0], 1'b0};
                end
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == '0) begin
                    q_out_s = quot_s;
                    r_out_s = prem_s[WIDTH-1:0];
                    dbz_s   = 1'b0;
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s == RUN);
        done_s = (state_s == FIN);
    end

    // State, working registers and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            dividend_r <= '0;
            divisor_r  <= '0;
            prem_r     <= '0;
            quot_r     <= '0;
            cnt_r      <= '0;
            Quotient   <= '0;
            Remainder  <= '0;
            DivByZero  <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state_r    <= state_s;
            dividend_r <= dividend_s;
            divisor_r  <= divisor_s;
            prem_r     <= prem_s;
            quot_r     <= quot_s;
            cnt_r      <= cnt_s;
            Quotient   <= q_out_s;
            Remainder  <= r_out_s;
            DivByZero  <= dbz_s;
            Busy       <= busy_s;
            Done       <= done_s;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: a cycle-level arithmetic reference model
// checked every cycle, plus directed scenarios with hand-computed results.
module tb_seq_divider;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Reset, Start;
    logic [W-1:0] A, B;
    logic         Busy, Done, DivByZero;
    logic [W-1:0] Quotient, Remainder;

    int checks = 0;
    int failures = 0;

    seq_divider #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
        .Busy(Busy), .Done(Done), .Quotient(Quotient),
        .Remainder(Remainder), .DivByZero(DivByZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted divide finishes WIDTH edges after acceptance,
    // a divide by zero finishes at the accepting edge itself.
    bit           m_valid = 1'b0;
    bit           m_busy, m_done, m_dbz;
    int           m_left;
    logic [W-1:0] m_q, m_r, p_q, p_r;

    always @(posedge Clk) begin
        if (Reset) begin
            m_valid = 1'b1;
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
            m_q = '0; m_r = '0; m_left = 0;
        end else if (!m_busy && Start) begin
            if (B == '0) begin
                m_done = 1'b1; m_q = '1; m_r = A; m_dbz = 1'b1;
            end else begin
                m_busy = 1'b1; m_done = 1'b0; m_left = W;
                p_q = A / B; p_r = A % B;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_done = 1'b1;
                m_q = p_q; m_r = p_r; m_dbz = 1'b0;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(posedge Clk) begin
        #1;
        if (m_valid) begin
            chk("busy",      int'(Busy),      int'(m_busy));
            chk("done",      int'(Done),      int'(m_done));
            chk("quotient",  int'(Quotient),  int'(m_q));
            chk("remainder", int'(Remainder), int'(m_r));
            chk("divbyzero", int'(DivByZero), int'(m_dbz));
        end
    end

    // Waits for Done; cyc counts negedges after launch, bcyc the Busy cycles seen.
    task automatic wait_done(input bit drop_start, output int cyc, output int bcyc);
        cyc = 0; bcyc = 0;
        do begin
            @(negedge Clk);
            if (drop_start && cyc == 0) Start = 1'b0;
            cyc++;
            if (Busy) bcyc++;
        end while (!Done && cyc < 20);
        if (!Done) chk("done_timeout", 0, 1);
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        Start = 1'b1; A = a; B = b;
    endtask

    int cyc, bcyc;

    initial begin
        Reset = 1'b1; Start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        chk("rst_busy", int'(Busy), 0);
        chk("rst_done", int'(Done), 0);
        chk("rst_q", int'(Quotient), 0);
        chk("rst_r", int'(Remainder), 0);
        chk("rst_dbz", int'(DivByZero), 0);

        // 13 / 4
        launch(4'd13, 4'd4);
        wait_done(1'b1, cyc, bcyc);
        chk("t1_latency", cyc, 5);
        chk("t1_busycycles", bcyc, 4);
        chk("t1_q", int'(Quotient), 3);
        chk("t1_r", int'(Remainder), 1);
        chk("t1_dbz", int'(DivByZero), 0);
        @(negedge Clk);
        chk("t1_done_pulse", int'(Done), 0);

        // 15 / 1, then 3 / 7 with hold check while running
        launch(4'd15, 4'd1);
        wait_done(1'b1, cyc, bcyc);
        chk("t2_q", int'(Quotient), 15);
        chk("t2_r", int'(Remainder), 0);
        @(negedge Clk);
        launch(4'd3, 4'd7);
        @(negedge Clk);
        Start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_q", int'(Quotient), 15);
            chk("t2_hold_r", int'(Remainder), 0);
            @(negedge Clk);
        end
        chk("t2b_done_now", int'(Done), 0);
        @(negedge Clk);
        chk("t2b_done", int'(Done), 1);
        chk("t2b_q", int'(Quotient), 0);
        chk("t2b_r", int'(Remainder), 3);

        // 9 / 0
        @(negedge Clk);
        launch(4'd9, 4'd0);
        wait_done(1'b1, cyc, bcyc);
        chk("t3_latency", cyc, 1);
        chk("t3_busycycles", bcyc, 0);
        chk("t3_dbz", int'(DivByZero), 1);
        chk("t3_q", int'(Quotient), 15);
        chk("t3_r", int'(Remainder), 9);
        @(negedge Clk);
        chk("t3_busy_after", int'(Busy), 0);
        chk("t3_done_after", int'(Done), 0);

        // 12 / 5 with an ignored Start on the second Busy cycle
        launch(4'd12, 4'd5);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        launch(4'd1, 4'd1);
        @(negedge Clk);
        Start = 1'b0;
        wait_done(1'b0, cyc, bcyc);
        chk("t4_latency_rest", cyc, 2);
        chk("t4_q", int'(Quotient), 2);
        chk("t4_r", int'(Remainder), 2);
        chk("t4_dbz", int'(DivByZero), 0);

        // 14 / 3 aborted by Reset, then rerun
        @(negedge Clk);
        launch(4'd14, 4'd3);
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("t5_busy", int'(Busy), 0);
        chk("t5_q", int'(Quotient), 0);
        chk("t5_r", int'(Remainder), 0);
        chk("t5_dbz", int'(DivByZero), 0);
        for (int i = 0; i < 6; i++) begin
            chk("t5_no_done", int'(Done), 0);
            @(negedge Clk);
        end
        launch(4'd14, 4'd3);
        wait_done(1'b1, cyc, bcyc);
        chk("t5b_latency", cyc, 5);
        chk("t5b_q", int'(Quotient), 4);
        chk("t5b_r", int'(Remainder), 2);

        // Exhaustive back-to-back sweep with Start held high through FIN
        @(negedge Clk);
        for (int idx = 0; idx < 256; idx++) begin
            logic [W-1:0] a, b;
            a = W'(idx >> 4);
            b = W'(idx & 15);
            launch(a, b);
            wait_done(1'b0, cyc, bcyc);
            chk("sw_interval", cyc, (b == '0) ? 1 : 5);
            if (b == '0) begin
                chk("sw_dbz", int'(DivByZero), 1);
                chk("sw_q_dbz", int'(Quotient), 15);
                chk("sw_r_dbz", int'(Remainder), int'(a));
            end else begin
                chk("sw_dbz", int'(DivByZero), 0);
                chk("sw_invariant", int'(Quotient) * int'(b) + int'(Remainder), int'(a));
                chk("sw_rem_lt_b", int'(Remainder < b), 1);
            end
        end
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        chk("end_idle_busy", int'(Busy), 0);
        chk("end_idle_done", int'(Done), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t required=<200000", $time);
        $fatal(1, "timeout");
    end

endmodule
